// File: rtl/my_nios1_mem_loader.sv
// Byte-stream loader for the Nios on-chip memory s2 port: packs bytes
// little-endian into 32-bit words and writes them from a programmed base.
module my_nios1_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W+2:0] byte_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken
);

    typedef enum logic [2:0] {IDLE, CHECK, COLLECT, WRITE, FINISH} state_e;

    localparam int CNT_W = ADDR_W + 3;
    // One extra bit so base*4 + count never truncates before the compare.
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(4 * DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       buf_q, buf_d;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d;
    logic [15:0]       sum_q, sum_d;
    logic [CNT_W:0]    end_byte;
    logic              accept;

    logic              in_ready_q, busy_q, done_q, error_q, write_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [3:0]        mem_byteenable_q;
    logic [31:0]       mem_writedata_q;

    assign accept   = in_valid && in_ready_q;
    assign end_byte = {2'b00, addr_q, 2'b00} + {1'b0, remaining_q};

    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        be_d        = be_q;
        err_d       = err_q;
        sum_d       = sum_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CHECK;
                    addr_d      = base_addr;
                    remaining_d = byte_count;
                    lane_d      = '0;
                    buf_d       = '0;
                    be_d        = '0;
                    err_d       = 1'b0;
                    sum_d       = '0;
                end
            end
            CHECK: begin
                if (end_byte > LIMIT) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (remaining_q == '0) begin
                    state_d = FINISH;
                end else begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    buf_d[{lane_q, 3'b000} +: 8] = in_data;
                    be_d[lane_q]                 = 1'b1;
                    sum_d                        = sum_q + {8'h00, in_data};
                    remaining_d                  = remaining_q - 1'b1;
                    lane_d                       = lane_q + 1'b1;
                    if (lane_q == 2'd3 || remaining_q == CNT_W'(1))
                        state_d = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + 1'b1;
                buf_d   = '0;
                be_d    = '0;
                lane_d  = '0;
                state_d = (remaining_q != '0) ? COLLECT : FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            remaining_q      <= '0;
            lane_q           <= '0;
            buf_q            <= '0;
            be_q             <= '0;
            err_q            <= 1'b0;
            sum_q            <= '0;
            in_ready_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
            write_q          <= 1'b0;
            mem_address_q    <= '0;
            mem_byteenable_q <= '0;
            mem_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remaining_q      <= remaining_d;
            lane_q           <= lane_d;
            buf_q            <= buf_d;
            be_q             <= be_d;
            err_q            <= err_d;
            sum_q            <= sum_d;
            in_ready_q       <= (state_d == COLLECT);
            busy_q           <= (state_d != IDLE);
            done_q           <= (state_d == FINISH);
            error_q          <= (state_d == FINISH) && err_d;
            write_q          <= (state_d == WRITE);
            mem_address_q    <= (state_d == WRITE) ? addr_q : '0;
            mem_byteenable_q <= (state_d == WRITE) ? be_d   : '0;
            mem_writedata_q  <= (state_d == WRITE) ? buf_d  : '0;
        end
    end

    assign in_ready       = in_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign checksum       = sum_q;
    assign mem_address    = mem_address_q;
    assign mem_byteenable = mem_byteenable_q;
    assign mem_chipselect = write_q;
    assign mem_write      = write_q;
    assign mem_writedata  = mem_writedata_q;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_my_nios1_mem_loader.sv
// Directed testbench for my_nios1_mem_loader: drives loads on the falling
// edge and checks writes, timing, flags and checksum against hand values.
module tb_my_nios1_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [12:0] byte_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready, busy, done, error;
    logic [15:0] checksum;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;

    int errors = 0;
    int checks = 0;

    logic [7:0]  stim [16];
    int          n_wr, done_k, last_wr_k;
    logic        err_seen, busy1, ready1, ready2, ready_in_write, busy_after;
    logic [9:0]  wr_addr [8];
    logic [3:0]  wr_be   [8];
    logic [31:0] wr_data [8];

    my_nios1_mem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .byte_count     (byte_count),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .checksum       (checksum),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // k counts falling edges after the one that raised start (k = cycle T+k).
    task automatic run_load(input logic [9:0] base, input logic [12:0] count,
                            input int nbytes, input bit gappy, input bit midstart);
        int idx;
        idx = 0; n_wr = 0; done_k = -1; last_wr_k = -1; err_seen = 1'b0;
        busy1 = 1'b0; ready1 = 1'b1; ready2 = 1'b0; ready_in_write = 1'b0;
        @(negedge clk);
        base_addr = base; byte_count = count; start = 1'b1; in_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (midstart && k == 4) begin
                start = 1'b1; base_addr = 10'd0; byte_count = 13'd0;
            end
            if (k == 1) begin busy1 = busy; ready1 = in_ready; end
            if (k == 2) ready2 = in_ready;
            if (mem_write) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = mem_address;
                    wr_be[n_wr]   = mem_byteenable;
                    wr_data[n_wr] = mem_writedata;
                end
                n_wr++;
                last_wr_k = k;
                if (in_ready) ready_in_write = 1'b1;
            end
            if (done) begin
                done_k = k; err_seen = error;
                break;
            end
            in_valid = (idx < nbytes) && (!gappy || (k % 2) == 1);
            in_data  = (idx < nbytes) ? stim[idx] : 8'h00;
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        base_addr = '0; byte_count = '0;
        repeat (3) @(negedge clk);
        checks++; if ({in_ready, busy, done, error, mem_chipselect, mem_write} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {in_ready, busy, done, error, mem_chipselect, mem_write}); end
        checks++; if ({mem_address, mem_byteenable, mem_writedata, checksum} !== '0) begin errors++; $display("FAIL reset_data: got addr=%h be=%h data=%h sum=%h expected zeros", mem_address, mem_byteenable, mem_writedata, checksum); end
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL reset_clken: got %b expected 1", mem_clken); end
        reset = 1'b0;
    endtask

    task automatic test_full_word();
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        run_load(10'd0, 13'd4, 4, 1'b0, 1'b0);
        checks++; if (busy1 !== 1'b1 || ready1 !== 1'b0 || ready2 !== 1'b1) begin errors++; $display("FAIL full_start_timing: busy@T+1=%b ready@T+1=%b ready@T+2=%b expected 1 0 1", busy1, ready1, ready2); end
        checks++; if (n_wr !== 1) begin errors++; $display("FAIL full_nwr: got %0d expected 1", n_wr); end
        checks++; if (wr_addr[0] !== 10'd0 || wr_be[0] !== 4'hF || wr_data[0] !== 32'h44332211) begin errors++; $display("FAIL full_write: got addr=%0d be=%h data=%h expected 0 f 44332211", wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if (last_wr_k !== 6 || done_k !== 7) begin errors++; $display("FAIL full_timing: write@%0d done@%0d expected 6 7", last_wr_k, done_k); end
        checks++; if (err_seen !== 1'b0 || busy_after !== 1'b0) begin errors++; $display("FAIL full_flags: error=%b busy_after=%b expected 0 0", err_seen, busy_after); end
        checks++; if (checksum !== 16'h00AA) begin errors++; $display("FAIL full_checksum: got %h expected 00aa", checksum); end
    endtask

    task automatic test_two_words();
        for (int i = 0; i < 6; i++) stim[i] = 8'(i + 1);
        run_load(10'd5, 13'd6, 6, 1'b0, 1'b0);
        checks++; if (n_wr !== 2) begin errors++; $display("FAIL two_nwr: got %0d expected 2", n_wr); end
        checks++; if (wr_addr[0] !== 10'd5 || wr_be[0] !== 4'hF || wr_data[0] !== 32'h04030201) begin errors++; $display("FAIL two_write0: got addr=%0d be=%h data=%h expected 5 f 04030201", wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if (wr_addr[1] !== 10'd6 || wr_be[1] !== 4'h3 || wr_data[1] !== 32'h00000605) begin errors++; $display("FAIL two_write1: got addr=%0d be=%h data=%h expected 6 3 00000605", wr_addr[1], wr_be[1], wr_data[1]); end
        checks++; if (last_wr_k !== 9 || done_k !== 10 || ready_in_write !== 1'b0) begin errors++; $display("FAIL two_timing: write@%0d done@%0d ready_in_write=%b expected 9 10 0", last_wr_k, done_k, ready_in_write); end
        checks++; if (checksum !== 16'h0015) begin errors++; $display("FAIL two_checksum: got %h expected 0015", checksum); end
    endtask

    task automatic test_range();
        stim[0] = 8'hDE; stim[1] = 8'hAD; stim[2] = 8'hBE; stim[3] = 8'hEF; stim[4] = 8'h01;
        run_load(10'd1023, 13'd5, 5, 1'b0, 1'b0);
        checks++; if (done_k !== 2 || err_seen !== 1'b1 || n_wr !== 0) begin errors++; $display("FAIL range_err: done@%0d error=%b writes=%0d expected 2 1 0", done_k, err_seen, n_wr); end
        checks++; if (checksum !== 16'h0000 || error !== 1'b0) begin errors++; $display("FAIL range_err_after: sum=%h error=%b expected 0000 0", checksum, error); end
        run_load(10'd1023, 13'd4, 4, 1'b0, 1'b0);
        checks++; if (n_wr !== 1 || wr_addr[0] !== 10'd1023 || wr_be[0] !== 4'hF || wr_data[0] !== 32'hEFBEADDE) begin errors++; $display("FAIL range_ok_write: n=%0d addr=%0d be=%h data=%h expected 1 1023 f efbeadde", n_wr, wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if (err_seen !== 1'b0 || done_k !== 7 || checksum !== 16'h0338) begin errors++; $display("FAIL range_ok_flags: error=%b done@%0d sum=%h expected 0 7 0338", err_seen, done_k, checksum); end
    endtask

    task automatic test_zero_length();
        run_load(10'd3, 13'd0, 0, 1'b0, 1'b0);
        checks++; if (done_k !== 2 || err_seen !== 1'b0 || n_wr !== 0) begin errors++; $display("FAIL zero_len: done@%0d error=%b writes=%0d expected 2 0 0", done_k, err_seen, n_wr); end
        checks++; if (checksum !== 16'h0000 || busy_after !== 1'b0) begin errors++; $display("FAIL zero_sum: sum=%h busy_after=%b expected 0000 0", checksum, busy_after); end
    endtask

    task automatic test_gappy_midstart();
        for (int i = 0; i < 8; i++) stim[i] = 8'hA0 + 8'(i);
        run_load(10'd20, 13'd8, 8, 1'b1, 1'b1);
        checks++; if (n_wr !== 2) begin errors++; $display("FAIL gappy_nwr: got %0d expected 2", n_wr); end
        checks++; if (wr_addr[0] !== 10'd20 || wr_be[0] !== 4'hF || wr_data[0] !== 32'hA3A2A1A0) begin errors++; $display("FAIL gappy_write0: got addr=%0d be=%h data=%h expected 20 f a3a2a1a0", wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if (wr_addr[1] !== 10'd21 || wr_be[1] !== 4'hF || wr_data[1] !== 32'hA7A6A5A4) begin errors++; $display("FAIL gappy_write1: got addr=%0d be=%h data=%h expected 21 f a7a6a5a4", wr_addr[1], wr_be[1], wr_data[1]); end
        checks++; if (done_k !== 19 || err_seen !== 1'b0 || checksum !== 16'h051C) begin errors++; $display("FAIL gappy_end: done@%0d error=%b sum=%h expected 19 0 051c", done_k, err_seen, checksum); end
    endtask

    task automatic test_reset_midload();
        int acc;
        acc = 0;
        stim[0] = 8'h05; stim[1] = 8'h07;
        @(negedge clk);
        base_addr = 10'd0; byte_count = 13'd8; start = 1'b1;
        for (int k = 0; k < 50 && acc < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1; in_data = stim[acc];
            if (in_ready) acc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (acc !== 2 || checksum !== 16'h000C) begin errors++; $display("FAIL midload_pre: accepted=%0d sum=%h expected 2 000c", acc, checksum); end
        reset = 1'b1;
        #1;
        checks++; if ({in_ready, busy, done, error, mem_chipselect, mem_write} !== 6'b0 || checksum !== 16'h0) begin errors++; $display("FAIL midload_reset: ctrl=%b sum=%h expected 000000 0000", {in_ready, busy, done, error, mem_chipselect, mem_write}, checksum); end
        @(negedge clk);
        reset = 1'b0;
        stim[0] = 8'h10; stim[1] = 8'h20; stim[2] = 8'h30; stim[3] = 8'h40;
        run_load(10'd10, 13'd4, 4, 1'b0, 1'b0);
        checks++; if (n_wr !== 1 || wr_addr[0] !== 10'd10 || wr_be[0] !== 4'hF || wr_data[0] !== 32'h40302010) begin errors++; $display("FAIL midload_reload: n=%0d addr=%0d be=%h data=%h expected 1 10 f 40302010", n_wr, wr_addr[0], wr_be[0], wr_data[0]); end
        checks++; if (checksum !== 16'h00A0 || done_k !== 7) begin errors++; $display("FAIL midload_reload_end: sum=%h done@%0d expected 00a0 7", checksum, done_k); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_two_words();
        test_range();
        test_zero_length();
        test_gappy_midstart();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
